pipe_ctrl_seq: RTL and testbench

// - Pipeline control sequencer. Consumes the hazard detector's stall and redirect requests plus the data-memory busy signal.
// - Drives the stall enables and flushes for the PC and the IF/ID, ID/EX and EX/MEM registers of the 5-stage core.
// - Sequences multi-cycle flushes and memory freezes, and guarantees exactly one bubble per load-use event.
// - Watchdog flags a pipeline that stops retiring.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl_seq_sat_counter.sv | 33 +++
 rtl/pipe_ctrl_seq.sv | 179 +++++++++++++++++
 tb/tb_pipe_ctrl_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control sequencer.
//   pipe_st_e  : sequencer state
//   pipe_ctl_t : the six pipeline-register control outputs
//   FL_W/WD_W  : counter widths for the flush and watchdog counters
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        BUBBLE,
        FLUSH,
        FREEZE
    } pipe_st_e;

    // Flush counter holds up to 7, watchdog counter up to 255.
    localparam int unsigned FL_W = 3;
    localparam int unsigned WD_W = 8;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                         idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0};
    localparam pipe_ctl_t CTL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                         idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1};
    localparam pipe_ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                         idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0};

endpackage

// File: rtl/pipe_ctrl_seq_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst : clock, async active-high reset
//   inc      : count up by one (held at MAX once reached)
//   clr      : clear to zero (wins over inc)
//   sat      : count equals MAX
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: pipeline control sequencer for the 5-stage core.
// Turns load-use / redirect / memory-busy requests into PC, IF/ID, ID/EX and
// EX/MEM enables and flushes; one bubble per load-use event, multi-cycle
// redirect flushes, whole-pipe freeze on mem_busy, plus a retire watchdog.
//   cpu_clk, reset            : clock, async active-high reset
//   ld_use_req, redirect      : hazard detector requests
//   mem_busy                  : data memory not ready (freeze)
//   wb_valid                  : instruction retires this cycle
//   pc_en .. exmem_en         : pipeline register controls (combinational)
//   stall_err                 : sticky watchdog error
//   stall_cnt, flush_cnt      : perf counters
// Optional feature: define PIPE_CTRL_PERF_EN to build the perf counters;
// otherwise stall_cnt/flush_cnt read as zero.
module pipe_ctrl_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_MAX    = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic             ld_use_req,
    input  logic             redirect,
    input  logic             mem_busy,
    input  logic             wb_valid,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_ONE    = FL_W'(1);

    pipe_st_e        state_q, state_d;
    pipe_st_e        ret_q, ret_d;
    logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;
    logic            bubble_done_q, bubble_done_d;
    logic            redir_pend_q, redir_pend_d;
    logic            stall_err_q, stall_err_d;

    pipe_st_e        eff_st;
    logic            redir_eff;
    logic            take_redir;
    logic            take_bubble;
    logic            wd_sat;
    pipe_ctl_t       ctl;

    // State register
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            ret_q         <= RUN;
            fl_cnt_q      <= '0;
            bubble_done_q <= 1'b0;
            redir_pend_q  <= 1'b0;
            stall_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            fl_cnt_q      <= fl_cnt_d;
            bubble_done_q <= bubble_done_d;
            redir_pend_q  <= redir_pend_d;
            stall_err_q   <= stall_err_d;
        end
    end

    // The cycle mem_busy drops in FREEZE already behaves as the saved state
    // (with any latched redirect), so leaving a freeze costs no extra cycle.
    always_comb begin
        eff_st    = state_q;
        redir_eff = redirect;
        if ((state_q == FREEZE) && !mem_busy) begin
            eff_st    = ret_q;
            redir_eff = redirect | redir_pend_q;
        end
        take_redir  = !mem_busy && redir_eff;
        take_bubble = !mem_busy && !redir_eff && (eff_st != FLUSH)
                      && ld_use_req && !bubble_done_q;
    end

    // Next-state
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        fl_cnt_d      = fl_cnt_q;
        redir_pend_d  = redir_pend_q;
        bubble_done_d = bubble_done_q & ld_use_req;
        stall_err_d   = stall_err_q | wd_sat;
        if (mem_busy) begin
            state_d = FREEZE;
            if (state_q != FREEZE) begin
                ret_d = state_q;
            end else begin
                redir_pend_d = redir_pend_q | redirect;
            end
        end else begin
            redir_pend_d = 1'b0;
            if (take_redir) begin
                fl_cnt_d = FL_RELOAD;
                state_d  = (FL_RELOAD != '0) ? FLUSH : RUN;
            end else if (eff_st == FLUSH) begin
                fl_cnt_d = fl_cnt_q - 1'b1;
                state_d  = (fl_cnt_q == FL_ONE) ? RUN : FLUSH;
            end else if (take_bubble) begin
                bubble_done_d = 1'b1;
                state_d       = BUBBLE;
            end else begin
                state_d = RUN;
            end
        end
    end

    // Outputs
    always_comb begin
        ctl = CTL_RUN;
        if (reset) begin
            ctl = CTL_RESET;
        end else if (mem_busy) begin
            ctl = CTL_FREEZE;
        end else if (take_redir || (eff_st == FLUSH)) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
        end else if (take_bubble) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
        end
    end

    assign pc_en      = ctl.pc_en;
    assign ifid_en    = ctl.ifid_en;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_en    = ctl.idex_en;
    assign idex_flush = ctl.idex_flush;
    assign exmem_en   = ctl.exmem_en;

    // Error shows in the same cycle the watchdog saturates, then stays set.
    assign stall_err = stall_err_q | wd_sat;

    sat_counter #(
        .WIDTH (WD_W),
        .MAX   (STALL_MAX)
    ) u_wd (
        .clk (cpu_clk),
        .rst (reset),
        .inc (!wb_valid && (state_q != FREEZE)),
        .clr (wb_valid),
        .sat (wd_sat)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (take_bubble) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (take_redir)  flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
module tb_pipe_ctrl_seq;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned STALL_MAX    = 15;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned VW           = 7 + 2 * CNT_W;

    // ctl bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en
    localparam logic [5:0] C_RUN    = 6'b110101;
    localparam logic [5:0] C_BUBBLE = 6'b000111;
    localparam logic [5:0] C_FLUSH  = 6'b111111;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_RESET  = 6'b001010;

    logic             cpu_clk;
    logic             reset;
    logic             ld_use_req, redirect, mem_busy, wb_valid;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic             stall_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Reference model: remaining flush cycles, freeze flag, pending redirect,
    // bubble-consumed flag, non-retire run length, sticky error, event totals.
    int unsigned m_flush_left;
    bit          m_freeze, m_pend, m_armed, m_err;
    int unsigned m_wd;
    logic [CNT_W-1:0] m_nstall, m_nflush;

    pipe_ctrl_seq #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .STALL_MAX    (STALL_MAX),
        .CNT_W        (CNT_W)
    ) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .ld_use_req (ld_use_req),
        .redirect   (redirect),
        .mem_busy   (mem_busy),
        .wb_valid   (wb_valid),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_en    (idex_en),
        .idex_flush (idex_flush),
        .exmem_en   (exmem_en),
        .stall_err  (stall_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    function automatic logic [VW-1:0] observed();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                stall_err, stall_cnt, flush_cnt};
    endfunction

    function automatic logic [CNT_W-1:0] perf(input logic [CNT_W-1:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return (v & '0);
`endif
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_freeze = 0; m_pend = 0; m_armed = 0; m_err = 0;
        m_wd = 0; m_nstall = '0; m_nflush = '0;
    endtask

    // Drives one cycle (entered at posedge+1), samples mid-cycle, advances
    // the model and returns at the next posedge+1.
    task automatic cycle(input bit l, input bit r, input bit m, input bit w,
                         output logic [VW-1:0] exp_v, output logic [VW-1:0] got_v);
        bit reff, bub;
        logic [5:0] c;
        bit err_out;
        ld_use_req = l; redirect = r; mem_busy = m; wb_valid = w;
        #3;
        reff = r || (m_freeze && m_pend);
        bub  = 0;
        if (m)                                  c = C_FREEZE;
        else if (reff || (m_flush_left > 0))    c = C_FLUSH;
        else if (l && !m_armed) begin           c = C_BUBBLE; bub = 1; end
        else                                    c = C_RUN;
        err_out = m_err || (m_wd == STALL_MAX);
        exp_v = {c, err_out, perf(m_nstall), perf(m_nflush)};
        got_v = observed();
        if (w) m_wd = 0;
        else if (!m_freeze && (m_wd < STALL_MAX)) m_wd++;
        m_err = err_out;
        if (!l) m_armed = 0;
        if (m) begin
            if (m_freeze) m_pend = m_pend | r;
            m_freeze = 1;
        end else begin
            if (reff) begin
                m_flush_left = FLUSH_CYCLES - 1;
                m_nflush = m_nflush + 1'b1;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (bub) begin
                m_armed = 1;
                m_nstall = m_nstall + 1'b1;
            end
            m_freeze = 0;
            m_pend = 0;
        end
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] e, g;
        reset = 1'b1;
        ld_use_req = 0; redirect = 0; mem_busy = 0; wb_valid = 0;
        model_reset();
        #3;
        g = observed();
        checks++;
        if (g !== {C_RESET, 1'b0, {(2*CNT_W){1'b0}}}) begin
            fails++;
            $display("FAIL reset_hold got=%h exp=%h", g, {C_RESET, 1'b0, {(2*CNT_W){1'b0}}});
        end
        @(posedge cpu_clk); #1;
        reset = 1'b0;
        cycle(0, 0, 0, 1, e, g);
        checks++;
        if (g !== e || g[VW-1 -: 6] !== C_RUN) begin
            fails++;
            $display("FAIL reset_release got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_load_use();
        logic [VW-1:0] e, g;
        int unsigned nb = 0;
        logic [CNT_W-1:0] base = m_nstall;
        for (int i = 0; i < 5; i++) begin
            cycle(i < 3, 0, 0, 1, e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL load_use cyc%0d got=%h exp=%h", i, g, e);
            end
            if (g[VW-1 -: 6] == C_BUBBLE) nb++;
        end
        checks++;
        if (nb != 1) begin
            fails++;
            $display("FAIL load_use_bubbles got=%0d exp=1", nb);
        end
        checks++;
        if (stall_cnt !== perf(base + 1'b1)) begin
            fails++;
            $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, perf(base + 1'b1));
        end
    endtask

    task automatic test_redirect();
        logic [VW-1:0] e, g;
        int unsigned nf = 0;
        logic [CNT_W-1:0] base = m_nflush;
        for (int i = 0; i < 4; i++) begin
            cycle(0, i == 0, 0, 1, e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL redirect cyc%0d got=%h exp=%h", i, g, e);
            end
            if (g[VW-1 -: 6] == C_FLUSH) nf++;
        end
        checks++;
        if (nf != FLUSH_CYCLES || flush_cnt !== perf(base + 1'b1)) begin
            fails++;
            $display("FAIL redirect_len got=%0d/%0d exp=%0d/%0d", nf, flush_cnt,
                     FLUSH_CYCLES, perf(base + 1'b1));
        end
    endtask

    task automatic test_freeze_flush();
        logic [VW-1:0] e, g;
        logic [5:0] seen [0:7];
        for (int i = 0; i < 8; i++) begin
            cycle(0, i == 0, (i >= 1) && (i <= 4), 1, e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL freeze_flush cyc%0d got=%h exp=%h", i, g, e);
            end
            seen[i] = g[VW-1 -: 6];
        end
        checks++;
        if (seen[1] !== C_FREEZE || seen[4] !== C_FREEZE || seen[5] !== C_FLUSH
            || seen[6] !== C_RUN) begin
            fails++;
            $display("FAIL freeze_seq got=%h,%h,%h,%h exp=%h,%h,%h,%h",
                     seen[1], seen[4], seen[5], seen[6], C_FREEZE, C_FREEZE, C_FLUSH, C_RUN);
        end
    endtask

    task automatic test_redirect_ld_same();
        logic [VW-1:0] e, g;
        logic [CNT_W-1:0] base = m_nstall;
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, i == 0, 0, 1, e, g);
            checks++;
            if (g !== e || g[VW-1 -: 6] == C_BUBBLE) begin
                fails++;
                $display("FAIL redir_ld cyc%0d got=%h exp=%h", i, g, e);
            end
        end
        checks++;
        if (stall_cnt !== perf(base)) begin
            fails++;
            $display("FAIL redir_ld_cnt got=%0d exp=%0d", stall_cnt, perf(base));
        end
    endtask

    task automatic test_watchdog();
        logic [VW-1:0] e, g;
        for (int i = 0; i < 19; i++) begin
            cycle(0, 0, 0, (i == 0) || (i >= 16), e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL watchdog cyc%0d got=%h exp=%h", i, g, e);
            end
        end
        checks++;
        if (stall_err !== 1'b1) begin
            fails++;
            $display("FAIL watchdog_sticky got=%b exp=1", stall_err);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] e, g;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 80, e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_seq();
        logic [VW-1:0] e, g;
        cycle(0, 1, 0, 1, e, g);
        cycle(0, 0, 1, 1, e, g);
        mem_busy = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        g = observed();
        checks++;
        if (g !== {C_RESET, 1'b0, {(2*CNT_W){1'b0}}}) begin
            fails++;
            $display("FAIL reset_mid got=%h exp=%h", g, {C_RESET, 1'b0, {(2*CNT_W){1'b0}}});
        end
        @(posedge cpu_clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, e, g);
            checks++;
            if (g !== e || g[VW-1 -: 6] !== C_RUN) begin
                fails++;
                $display("FAIL reset_mid_after cyc%0d got=%h exp=%h", i, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_freeze_flush();
        test_redirect_ld_same();
        test_watchdog();
        test_random();
        test_reset_mid_seq();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
